serial_adder: RTL and testbench

Bit-serial W-bit adder that consumes operands from the datapath registers and produces a registered sum and carry-out after W clock cycles. Each cycle it adds one bit pair, LSB first, using a full-adder slice built from two half-adder cells plus an OR, with a carry flip-flop between bits. It is the area-minimal alternative to a W-bit ripple adder and sits directly downstream of the half-adder cell, which it instantiates as its per-bit core.

---
 rtl/serial_adder.sv | 175 +++++++++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial W-bit adder built from a half-adder cell
//
// Purpose:
//   Adds two W-bit operands one bit pair per clock, LSB first, using a full
//   adder made of two half_adder cells plus an OR. A carry flip-flop links
//   consecutive bits. The result and carry-out are registered after W cycles.
//
// Optional feature:
//   SERIAL_ADDER_SUB_EN - adds the sub port; sub=1 computes a - b by inverting
//   b and seeding the carry with 1 (cout=1 then means no borrow).
//
// Ports (serial_adder):
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an addition; only looked at while idle
//   a, b   in   W-bit operands, captured on the accepting edge
//   sub    in   subtract mode (SERIAL_ADDER_SUB_EN only), captured with a, b
//   busy   out  operation in progress
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  W-bit result, held until the next completion
//   cout   out  carry out of bit W-1, held with sum
//
// Ports (half_adder):
//   x, y   in   operand bits
//   s, c   out  sum and carry bits

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic [W-1:0]   sum_sr;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic           sub_eff;
    logic           ha0_s;
    logic           ha0_c;
    logic           s_bit;
    logic           ha1_c;
    logic           carry_nxt;
    logic           last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Full-adder slice: first cell adds the operand bits, second folds in
    // the stored carry. At most one of the two cells can generate a carry,
    // so an OR is enough to merge them.
    half_adder u_ha0 (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .x (ha0_s),
        .y (carry),
        .s (s_bit),
        .c (ha1_c)
    );

    assign carry_nxt = ha0_c | ha1_c;
    assign last_bit  = (cnt == LAST_CNT);

    // busy follows the registered state, so it is glitch-free
    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b once here and
                        // let the initial carry supply the +1.
                        a_sr  <= a;
                        b_sr  <= sub_eff ? ~b : b;
                        carry <= sub_eff;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    carry  <= carry_nxt;
                    sum_sr <= {s_bit, sum_sr[W-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // The final bit is still in flight, so publish the
                        // shifted value directly rather than sum_sr.
                        sum  <= {s_bit, sum_sr[W-1:1]};
                        cout <= carry_nxt;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder (W=8 and W=13)

module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        start_v;
    logic [1:0]        sub_v;
    logic [1:0]        busy_v;
    logic [1:0]        done_v;
    logic [1:0][15:0]  a_v;
    logic [1:0][15:0]  b_v;
    logic [1:0][16:0]  act_v;
    logic [1:0][16:0]  exp_v;
    logic [1:0]        mbusy_v;
    logic [1:0]        mdone_v;

    int checks = 0;
    int errors = 0;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int WW = (g == 0) ? 8 : 13;

        logic          busy_w;
        logic          done_w;
        logic          cout_w;
        logic [WW-1:0] sum_w;

        serial_adder #(.W(WW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[g]),
            .a     (a_v[g][WW-1:0]),
            .b     (b_v[g][WW-1:0]),
`ifdef SERIAL_ADDER_SUB_EN
            .sub   (sub_v[g]),
`endif
            .busy  (busy_w),
            .done  (done_w),
            .sum   (sum_w),
            .cout  (cout_w)
        );

        assign busy_v[g] = busy_w;
        assign done_v[g] = done_w;
        assign act_v[g]  = 17'({cout_w, sum_w});

        // Reference: an accepted request yields {cout,sum} = a + b (or
        // a + ~b + 1) exactly WW edges later; requests while busy are dropped.
        int          rem    = 0;
        logic [WW:0] pend   = '0;
        logic [WW:0] held   = '0;
        logic        m_busy = 1'b0;
        logic        m_done = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem    = 0;
                pend   = '0;
                held   = '0;
                m_busy = 1'b0;
                m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (rem > 0) begin
                    rem = rem - 1;
                    if (rem == 0) begin
                        held   = pend;
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else if (start_v[g]) begin
                    if (SUB_EN && sub_v[g])
                        pend = (WW+1)'(a_v[g][WW-1:0]) + (WW+1)'(~b_v[g][WW-1:0]) + (WW+1)'(1);
                    else
                        pend = (WW+1)'(a_v[g][WW-1:0]) + (WW+1)'(b_v[g][WW-1:0]);
                    rem    = WW;
                    m_busy = 1'b1;
                end
            end
        end

        assign exp_v[g]   = 17'(held);
        assign mbusy_v[g] = m_busy;
        assign mdone_v[g] = m_done;
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("cmp_busy%0d", g), 32'(busy_v[g]), 32'(mbusy_v[g]));
            chk($sformatf("cmp_done%0d", g), 32'(done_v[g]), 32'(mdone_v[g]));
            chk($sformatf("cmp_cout_sum%0d", g), 32'(act_v[g]), 32'(exp_v[g]));
        end
    end

    // Starts an operation in the current cycle and waits for done. Returns
    // the sample index of done (1 = first sample after the accepting edge)
    // and the number of samples with busy high. With junk set, inputs are
    // scrambled and start is wiggled while the operation runs.
    task automatic run_op(input int g, input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input bit junk, output int k_done, output int nbusy);
        start_v[g] = 1'b1;
        a_v[g]     = a;
        b_v[g]     = b;
        sub_v[g]   = s;
        k_done     = 0;
        nbusy      = 0;
        for (int k = 1; k <= 3 * w; k++) begin
            @(negedge clk);
            if (done_v[g]) begin
                k_done = k;
                break;
            end
            if (busy_v[g]) nbusy++;
            #1;
            if (k == 1) begin
                start_v[g] = 1'b0;
            end else if (junk && k < w) begin
                start_v[g] = 1'($urandom % 2);
                a_v[g]     = 16'($urandom);
                b_v[g]     = 16'($urandom);
                sub_v[g]   = 1'($urandom % 2);
            end else if (k == w) begin
                start_v[g] = 1'b0;
            end
        end
        #1;
        start_v[g] = 1'b0;
    endtask

    task automatic rand_ops(input int g, input int w, input int n);
        int k;
        int nb;
        logic [15:0] mask;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        mask = 16'((32'd1 << w) - 1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
            ra = 16'($urandom) & mask;
            rb = 16'($urandom) & mask;
            rs = SUB_EN ? 1'($urandom % 2) : 1'b0;
            run_op(g, w, ra, rb, rs, 1'b1, k, nb);
            chk($sformatf("rand_latency%0d", g), 32'(k), 32'(w + 1));
        end
    endtask

    initial begin
        int k;
        int nb;
        int nd;

        rst_n   = 1'b0;
        start_v = '0;
        sub_v   = '0;
        a_v     = '0;
        b_v     = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy_v[0]), 32'd0);
        chk("reset_done", 32'(done_v[0]), 32'd0);
        chk("reset_cout_sum", 32'(act_v[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // 0x0F + 0x01
        run_op(0, 8, 16'h0F, 16'h01, 1'b0, 1'b0, k, nb);
        chk("t1_latency", 32'(k), 32'd9);
        chk("t1_busy_cycles", 32'(nb), 32'd8);
        chk("t1_cout_sum", 32'(act_v[0]), 32'h010);
        chk("t1_model", 32'(exp_v[0]), 32'h010);

        // 0xFF + 0x01 wraps with carry out, then back-to-back 0xA5 + 0x5A
        run_op(0, 8, 16'hFF, 16'h01, 1'b0, 1'b0, k, nb);
        chk("t2_cout_sum", 32'(act_v[0]), 32'h100);
        chk("t2_model", 32'(exp_v[0]), 32'h100);
        run_op(0, 8, 16'hA5, 16'h5A, 1'b0, 1'b0, k, nb);
        chk("t2b_latency", 32'(k), 32'd9);
        chk("t2b_cout_sum", 32'(act_v[0]), 32'h0FF);

        // restart while busy must be ignored, operands already captured
        start_v[0] = 1'b1;
        a_v[0]     = 16'h3C;
        b_v[0]     = 16'h3C;
        nd         = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_v[0]) nd++;
            #1;
            if (i == 1) start_v[0] = 1'b0;
            if (i == 3) begin
                start_v[0] = 1'b1;
                a_v[0]     = 16'h00;
                b_v[0]     = 16'h00;
            end
            if (i == 4) start_v[0] = 1'b0;
        end
        chk("t3_done_pulses", 32'(nd), 32'd1);
        chk("t3_cout_sum", 32'(act_v[0]), 32'h078);

        // reset mid-operation
        start_v[0] = 1'b1;
        a_v[0]     = 16'h55;
        b_v[0]     = 16'h33;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) start_v[0] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("t4_busy", 32'(busy_v[0]), 32'd0);
        chk("t4_done", 32'(done_v[0]), 32'd0);
        chk("t4_cout_sum", 32'(act_v[0]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
        nd    = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_v[0]) nd++;
            #1;
        end
        chk("t4_no_done", 32'(nd), 32'd0);
        run_op(0, 8, 16'h01, 16'h01, 1'b0, 1'b0, k, nb);
        chk("t4_after_cout_sum", 32'(act_v[0]), 32'h002);
        chk("t4_after_model", 32'(exp_v[0]), 32'h002);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 8, 16'h07, 16'h05, 1'b1, 1'b0, k, nb);
        chk("sub1_cout_sum", 32'(act_v[0]), 32'h102);
        run_op(0, 8, 16'h05, 16'h07, 1'b1, 1'b0, k, nb);
        chk("sub2_cout_sum", 32'(act_v[0]), 32'h0FE);
`endif

        fork
            rand_ops(0, 8, 1000);
            rand_ops(1, 13, 1000);
        join

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
